// File: rtl/character_counter.sv
// One digit of a charset odometer: steps through a programmable character
// list on carry_in and requests a carry when it wraps.
module character_counter #(
  parameter int MAX_CHARS = 127,
  parameter int CHAR_W    = 8
) (
  input  logic                      i_count,
  input  logic                      i_rst_n,
  input  logic                      i_program,
  input  logic [7:0]                i_prg_numchars,
  input  logic [CHAR_W*MAX_CHARS-1:0] i_prg_charlist,
  input  logic                      i_enable,
  input  logic                      i_carry_in,
  output logic                      o_carry_out,
  output logic [CHAR_W-1:0]         o_char
);

  localparam logic [7:0] MAXN = 8'(MAX_CHARS);

  logic [CHAR_W*MAX_CHARS-1:0] r_charlist;
  logic [7:0]                  r_numchars;
  logic [6:0]                  r_index;

  logic [7:0] w_len;
  logic [7:0] w_last;
  logic [7:0] w_prg_n;
  logic       w_adv;
  logic       w_at_last;
  logic [6:0] w_index_nxt;

  // An empty charset behaves as a single-entry digit.
  assign w_len  = (r_numchars == 8'd0) ? 8'd1 : r_numchars;
  assign w_last = w_len - 8'd1;

  // >= also recovers an index left beyond the list end.
  assign w_at_last = ({1'b0, r_index} >= w_last);
  assign w_adv     = i_enable & i_carry_in;

  assign w_prg_n = (i_prg_numchars > MAXN) ? MAXN : i_prg_numchars;

  assign w_index_nxt = w_at_last ? 7'd0 : r_index + 7'd1;

  assign o_carry_out = w_adv & w_at_last;

  always_comb begin
    o_char = '0;
    if (i_enable)
      o_char = r_charlist[CHAR_W*r_index +: CHAR_W];
  end

  always_ff @(posedge i_count or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_charlist <= '0;
      r_numchars <= '0;
      r_index    <= '0;
    end else if (i_program) begin
      r_charlist <= i_prg_charlist;
      r_numchars <= w_prg_n;
      r_index    <= '0;
    end else if (w_adv) begin
      r_index    <= w_index_nxt;
    end
  end

endmodule

// File: tb/tb_character_counter.sv
// Self-checking bench for character_counter: directed scenarios plus
// randomized traffic against a list/modulo reference model.
module tb_character_counter;

  localparam int MC = 127;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic lo_pg, hi_pg;
  logic [7:0] lo_n, hi_n;
  logic [CW*MC-1:0] lo_list, hi_list;
  logic lo_en, hi_en, lo_ci;
  logic lo_co, hi_co;
  logic [CW-1:0] lo_ch, hi_ch;

  always #5 clk = ~clk;

  character_counter #(.MAX_CHARS(MC), .CHAR_W(CW)) u_lo (
    .i_count(clk), .i_rst_n(rst_n), .i_program(lo_pg),
    .i_prg_numchars(lo_n), .i_prg_charlist(lo_list),
    .i_enable(lo_en), .i_carry_in(lo_ci),
    .o_carry_out(lo_co), .o_char(lo_ch)
  );

  character_counter #(.MAX_CHARS(MC), .CHAR_W(CW)) u_hi (
    .i_count(clk), .i_rst_n(rst_n), .i_program(hi_pg),
    .i_prg_numchars(hi_n), .i_prg_charlist(hi_list),
    .i_enable(hi_en), .i_carry_in(lo_co),
    .o_carry_out(hi_co), .o_char(hi_ch)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m_list [MC];
  int m_len;
  int m_idx;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_lo(input int n);
    lo_list = '0;
    for (int k = 0; k < MC; k++) lo_list[CW*k +: CW] = m_list[k];
    lo_n  = n[7:0];
    lo_pg = 1'b1;
    tick();
    lo_pg = 1'b0;
    m_len = (n > MC) ? MC : n;
    if (m_len == 0) m_len = 1;
    m_idx = 0;
  endtask

  task automatic set_abc;
    for (int k = 0; k < MC; k++) m_list[k] = 8'h00;
    m_list[0] = "a";
    m_list[1] = "b";
    m_list[2] = "c";
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lo_en = 1'b1;
    lo_ci = 1'b1;
    #1;
    n_cmp++;
    if (lo_ch !== 8'h00) begin
      n_err++;
      $display("FAIL reset_char got %h want 00", lo_ch);
    end
    n_cmp++;
    if (lo_co !== 1'b1) begin
      n_err++;
      $display("FAIL reset_carry got %b want 1", lo_co);
    end
    lo_ci = 1'b0;
    #1;
    n_cmp++;
    if (lo_co !== 1'b0) begin
      n_err++;
      $display("FAIL reset_carry_noci got %b want 0", lo_co);
    end
    #1 rst_n = 1'b1;
    lo_ci = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (lo_ch !== 8'h00 || lo_co !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_edge got %h/%b want 00/1", lo_ch, lo_co);
    end
    @(negedge clk);
  endtask

  task automatic test_abc;
    logic [7:0] exp [4];
    exp[0] = "a"; exp[1] = "b"; exp[2] = "c"; exp[3] = "a";
    set_abc();
    load_lo(3);
    lo_en = 1'b1;
    lo_ci = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (lo_ch !== exp[i] || lo_co !== (i == 2)) begin
        n_err++;
        $display("FAIL abc[%0d] got %h/%b want %h/%b",
                 i, lo_ch, lo_co, exp[i], (i == 2));
      end
      tick();
    end
  endtask

  task automatic test_hold;
    set_abc();
    load_lo(3);
    lo_en = 1'b1;
    lo_ci = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_cmp++;
      if (lo_ch !== "a" || lo_co !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d] got %h/%b want 61/0", i, lo_ch, lo_co);
      end
    end
  endtask

  task automatic test_enable;
    set_abc();
    load_lo(3);
    lo_en = 1'b1;
    lo_ci = 1'b1;
    tick();
    lo_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (lo_ch !== 8'h00 || lo_co !== 1'b0) begin
        n_err++;
        $display("FAIL disabled[%0d] got %h/%b want 00/0", i, lo_ch, lo_co);
      end
      tick();
    end
    lo_en = 1'b1;
    lo_ci = 1'b0;
    #1;
    n_cmp++;
    if (lo_ch !== "b") begin
      n_err++;
      $display("FAIL reenable got %h want 62", lo_ch);
    end
  endtask

  task automatic test_prog_prio;
    set_abc();
    load_lo(3);
    lo_en = 1'b1;
    lo_ci = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++;
    if (lo_ch !== "c") begin
      n_err++;
      $display("FAIL prio_setup got %h want 63", lo_ch);
    end
    lo_pg = 1'b1;
    tick();
    lo_pg = 1'b0;
    lo_ci = 1'b0;
    #1;
    n_cmp++;
    if (lo_ch !== "a") begin
      n_err++;
      $display("FAIL prog_priority got %h want 61", lo_ch);
    end
  endtask

  task automatic test_chain;
    logic [7:0] el, eh;
    lo_list = '0;
    hi_list = '0;
    lo_list[7:0] = "0"; lo_list[15:8] = "1";
    hi_list[7:0] = "0"; hi_list[15:8] = "1";
    lo_n = 8'd2;
    hi_n = 8'd2;
    lo_pg = 1'b1;
    hi_pg = 1'b1;
    lo_ci = 1'b0;
    tick();
    lo_pg = 1'b0;
    hi_pg = 1'b0;
    lo_en = 1'b1;
    hi_en = 1'b1;
    lo_ci = 1'b1;
    for (int v = 0; v < 5; v++) begin
      el = ((v % 2) == 1) ? "1" : "0";
      eh = (((v / 2) % 2) == 1) ? "1" : "0";
      #1;
      n_cmp++;
      if (lo_ch !== el || hi_ch !== eh) begin
        n_err++;
        $display("FAIL chain[%0d] got %h%h want %h%h",
                 v, lo_ch, hi_ch, el, eh);
      end
      tick();
    end
    hi_en = 1'b0;
  endtask

  task automatic test_len_one;
    for (int k = 0; k < MC; k++) m_list[k] = 8'($urandom);
    load_lo(0);
    lo_en = 1'b1;
    lo_ci = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (lo_ch !== m_list[0] || lo_co !== 1'b1) begin
        n_err++;
        $display("FAIL len_one[%0d] got %h/%b want %h/1",
                 i, lo_ch, lo_co, m_list[0]);
      end
      tick();
    end
  endtask

  task automatic test_random;
    logic en, ci, pg;
    logic [7:0] ech;
    logic eco;
    int n;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < MC; k++) m_list[k] = 8'($urandom);
      n = $urandom_range(0, 12);
      load_lo(n);
      for (int c = 0; c < 30; c++) begin
        en = ($urandom_range(0, 9) < 8);
        ci = ($urandom_range(0, 9) < 7);
        pg = ($urandom_range(0, 19) == 0);
        lo_en = en;
        lo_ci = ci;
        lo_pg = pg;
        ech = en ? m_list[m_idx] : 8'h00;
        eco = en && ci && (m_idx == m_len - 1);
        #1;
        n_cmp++;
        if (lo_ch !== ech || lo_co !== eco) begin
          n_err++;
          $display("FAIL random[%0d.%0d] got %h/%b want %h/%b",
                   r, c, lo_ch, lo_co, ech, eco);
        end
        tick();
        if (pg) m_idx = 0;
        else if (en && ci) m_idx = (m_idx + 1) % m_len;
      end
      lo_pg = 1'b0;
    end
  endtask

  task automatic test_wrap_reset;
    logic eco;
    for (int k = 0; k < MC; k++) m_list[k] = 8'($urandom);
    load_lo(200);
    lo_en = 1'b1;
    lo_ci = 1'b1;
    for (int i = 0; i < 130; i++) begin
      eco = (m_idx == 126);
      #1;
      n_cmp++;
      if (lo_ch !== m_list[m_idx] || lo_co !== eco) begin
        n_err++;
        $display("FAIL wrap[%0d] got %h/%b want %h/%b",
                 i, lo_ch, lo_co, m_list[m_idx], eco);
      end
      tick();
      m_idx = (m_idx + 1) % m_len;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lo_ch !== 8'h00 || lo_co !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_reset got %h/%b want 00/1", lo_ch, lo_co);
    end
    #1 rst_n = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (lo_ch !== 8'h00) begin
      n_err++;
      $display("FAIL after_midrun_reset got %h want 00", lo_ch);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    lo_pg   = 1'b0;
    hi_pg   = 1'b0;
    lo_n    = '0;
    hi_n    = '0;
    lo_list = '0;
    hi_list = '0;
    lo_en   = 1'b0;
    hi_en   = 1'b0;
    lo_ci   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_abc();
    test_hold();
    test_enable();
    test_prog_prio();
    test_chain();
    test_len_one();
    test_random();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
